// File: rtl/multichannel_minmax_detector_if.sv
// rtl/multichannel_minmax_detector_if.sv - sample input stream and span/trigger output bundle
interface multichannel_minmax_detector_if #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int NUM_CHANNELS      = 2
);
    localparam int W  = SAMPLE_DATA_WIDTH;
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                    axiiv;
    logic [W-1:0]            axiid;
    logic [CW-1:0]           axiic;
    logic                    span_axiov;
    logic [W:0]              span_axiod;
    logic [CW-1:0]           span_axioc;
    logic [NUM_CHANNELS-1:0] channel_triggered;
    logic                    triggered;

    modport master (
        output axiiv, axiid, axiic,
        input  span_axiov, span_axiod, span_axioc, channel_triggered, triggered
    );

    modport slave (
        input  axiiv, axiid, axiic,
        output span_axiov, span_axiod, span_axioc, channel_triggered, triggered
    );
endinterface

// File: rtl/multichannel_minmax_detector.sv
// rtl/multichannel_minmax_detector.sv - per-channel windowed min/max span detector with hysteresis and hang-over
module multichannel_minmax_detector #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int NUM_CHANNELS      = 2,
    parameter int LOOK_BACK         = 50,
    parameter int LOW_THRESHOLD     = 37,
    parameter int HIGH_THRESHOLD    = 74,
    parameter int HOLD_WINDOWS      = 2,
    parameter int COMBINE_MODE      = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multichannel_minmax_detector_if.slave bus
);
    localparam int W    = SAMPLE_DATA_WIDTH;
    localparam int CW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNTW = $clog2(LOOK_BACK);
    localparam int HW   = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;

    localparam logic [W:0]      LOW_T    = (W+1)'(LOW_THRESHOLD);
    localparam logic [W:0]      HIGH_T   = (W+1)'(HIGH_THRESHOLD);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(LOOK_BACK - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        HANGOVER = 2'd2
    } state_t;

    logic signed [W-1:0]     sample;
    logic [NUM_CHANNELS-1:0] hit;
    logic [NUM_CHANNELS-1:0] close;
    logic [NUM_CHANNELS-1:0] flags_d;
    logic [CNTW-1:0]         cnt_q [NUM_CHANNELS];
    logic [CNTW-1:0]         cnt_d [NUM_CHANNELS];
    logic signed [W-1:0]     min_q [NUM_CHANNELS];
    logic signed [W-1:0]     min_d [NUM_CHANNELS];
    logic signed [W-1:0]     max_q [NUM_CHANNELS];
    logic signed [W-1:0]     max_d [NUM_CHANNELS];
    logic [W:0]              span  [NUM_CHANNELS];
    state_t                  state_q [NUM_CHANNELS];
    state_t                  state_d [NUM_CHANNELS];
    logic [HW-1:0]           hold_q  [NUM_CHANNELS];
    logic [HW-1:0]           hold_d  [NUM_CHANNELS];
    logic [W:0]              sel_span;
    logic [CW-1:0]           sel_ch;

    assign sample = $signed(bus.axiid);

    // Window tracking: an out-of-range channel index matches no channel and is dropped
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            hit[c]   = bus.axiiv && (bus.axiic == CW'(c));
            min_d[c] = ((cnt_q[c] == '0) || (sample < min_q[c])) ? sample : min_q[c];
            max_d[c] = ((cnt_q[c] == '0) || (sample > max_q[c])) ? sample : max_q[c];
            close[c] = hit[c] && (cnt_q[c] == LAST_CNT);
            cnt_d[c] = close[c] ? '0 : cnt_q[c] + CNTW'(1);
            // sign-extend by one bit so max-min always fits unsigned in W+1 bits
            span[c]  = {max_d[c][W-1], max_d[c]} - {min_d[c][W-1], min_d[c]};
        end
    end

    // Per-channel FSM next state, evaluated only when that channel's window closes
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            hold_d[c]  = hold_q[c];
            if (close[c]) begin
                case (state_q[c])
                    IDLE: begin
                        if (span[c] >= HIGH_T) state_d[c] = ACTIVE;
                    end
                    ACTIVE: begin
                        if (span[c] < LOW_T) begin
                            if (HOLD_WINDOWS == 0) begin
                                state_d[c] = IDLE;
                            end else begin
                                state_d[c] = HANGOVER;
                                hold_d[c]  = HW'(HOLD_WINDOWS);
                            end
                        end
                    end
                    HANGOVER: begin
                        if (span[c] >= HIGH_T) begin
                            state_d[c] = ACTIVE;
                        end else if (hold_q[c] <= HW'(1)) begin
                            state_d[c] = IDLE;
                            hold_d[c]  = '0;
                        end else begin
                            hold_d[c]  = hold_q[c] - HW'(1);
                        end
                    end
                    default: state_d[c] = IDLE;
                endcase
            end
            flags_d[c] = (state_d[c] != IDLE);
        end
    end

    // Select the closing channel's span for the output stream (at most one closes per cycle)
    always_comb begin
        sel_span = '0;
        sel_ch   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (close[c]) begin
                sel_span = span[c];
                sel_ch   = CW'(c);
            end
        end
    end

    // Per-channel window and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                cnt_q[c]   <= '0;
                min_q[c]   <= '0;
                max_q[c]   <= '0;
                state_q[c] <= IDLE;
                hold_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (hit[c]) begin
                    cnt_q[c] <= cnt_d[c];
                    min_q[c] <= min_d[c];
                    max_q[c] <= max_d[c];
                end
                state_q[c] <= state_d[c];
                hold_q[c]  <= hold_d[c];
            end
        end
    end

    // Registered outputs: span pulse and trigger flags all change one cycle after the closing sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.span_axiov        <= 1'b0;
            bus.span_axiod        <= '0;
            bus.span_axioc        <= '0;
            bus.channel_triggered <= '0;
            bus.triggered         <= 1'b0;
        end else begin
            bus.span_axiov        <= |close;
            if (|close) begin
                bus.span_axiod    <= sel_span;
                bus.span_axioc    <= sel_ch;
            end
            bus.channel_triggered <= flags_d;
            bus.triggered         <= (COMBINE_MODE != 0) ? (&flags_d) : (|flags_d);
        end
    end
endmodule

// File: tb/tb_multichannel_minmax_detector.sv
// tb/tb_multichannel_minmax_detector.sv - scoreboard bench for single- and dual-channel detector configurations
module tb_multichannel_minmax_detector;
    logic clk;
    logic rst_n;

    typedef struct {
        int span;
        int ch;
        int ct;
        int trig;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int total;
    int bad;
    int closes_a;
    int snap;

    multichannel_minmax_detector_if #(.SAMPLE_DATA_WIDTH(8), .NUM_CHANNELS(1)) ifa ();
    multichannel_minmax_detector_if #(.SAMPLE_DATA_WIDTH(8), .NUM_CHANNELS(2)) ifb ();
    multichannel_minmax_detector_if #(.SAMPLE_DATA_WIDTH(8), .NUM_CHANNELS(2)) ifc ();

    multichannel_minmax_detector #(.NUM_CHANNELS(1), .COMBINE_MODE(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    multichannel_minmax_detector #(.NUM_CHANNELS(2), .COMBINE_MODE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    multichannel_minmax_detector #(.NUM_CHANNELS(2), .COMBINE_MODE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_close(input string who, input exp_t e, input int sp, input int ch, input int ct, input int tr);
        check({who, " span"}, sp, e.span);
        check({who, " chan"}, ch, e.ch);
        check({who, " channel_triggered"}, ct, e.ct);
        check({who, " triggered"}, tr, e.trig);
    endtask

    // Monitors: pop an expectation for every window-close pulse seen
    always @(negedge clk) begin
        if (rst_n && ifa.span_axiov) begin
            closes_a++;
            if (qa.size() == 0) check("a unexpected close", 1, 0);
            else cmp_close("a", qa.pop_front(), int'(ifa.span_axiod), int'(ifa.span_axioc),
                           int'(ifa.channel_triggered), int'(ifa.triggered));
        end
        if (rst_n && ifb.span_axiov) begin
            if (qb.size() == 0) check("b unexpected close", 1, 0);
            else cmp_close("b", qb.pop_front(), int'(ifb.span_axiod), int'(ifb.span_axioc),
                           int'(ifb.channel_triggered), int'(ifb.triggered));
        end
        if (rst_n && ifc.span_axiov) begin
            if (qc.size() == 0) check("c unexpected close", 1, 0);
            else cmp_close("c", qc.pop_front(), int'(ifc.span_axiod), int'(ifc.span_axioc),
                           int'(ifc.channel_triggered), int'(ifc.triggered));
        end
    end

    task automatic drive_a(input int v, input int ch, input bit vld);
        ifa.axiiv = vld;
        ifa.axiid = v[7:0];
        ifa.axiic = ch[0];
        @(posedge clk);
        #1;
        ifa.axiiv = 1'b0;
    endtask

    task automatic drive_bc(input int v, input int ch);
        ifb.axiiv = 1'b1;
        ifb.axiid = v[7:0];
        ifb.axiic = ch[0];
        ifc.axiiv = 1'b1;
        ifc.axiid = v[7:0];
        ifc.axiic = ch[0];
        @(posedge clk);
        #1;
        ifb.axiiv = 1'b0;
        ifc.axiiv = 1'b0;
    endtask

    function automatic exp_t mk(input int sp, input int ch, input int ct, input int tr);
        exp_t e;
        e.span = sp;
        e.ch   = ch;
        e.ct   = ct;
        e.trig = tr;
        return e;
    endfunction

    task automatic win_a(input int hi, input int lo, input int sp, input int ct, input int tr);
        qa.push_back(mk(sp, 0, ct, tr));
        for (int i = 0; i < 50; i++) drive_a((i % 2 == 0) ? hi : lo, 0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        closes_a = 0;
        rst_n = 1'b0;
        ifa.axiiv = 1'b0; ifa.axiid = '0; ifa.axiic = '0;
        ifb.axiiv = 1'b0; ifb.axiid = '0; ifb.axiic = '0;
        ifc.axiiv = 1'b0; ifc.axiid = '0; ifc.axiic = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset span_axiov", int'(ifa.span_axiov), 0);
        check("reset span_axiod", int'(ifa.span_axiod), 0);
        check("reset channel_triggered", int'(ifb.channel_triggered), 0);
        check("reset triggered", int'(ifb.triggered), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        win_a(50, -50, 100, 1, 1);
        win_a(25, -25, 50, 1, 1);
        win_a(5, -5, 10, 1, 1);
        win_a(5, -5, 10, 1, 1);
        win_a(5, -5, 10, 0, 0);
        win_a(50, -50, 100, 1, 1);
        win_a(5, -5, 10, 1, 1);
        win_a(37, -37, 74, 1, 1);
        win_a(18, -19, 37, 1, 1);
        win_a(127, -128, 255, 1, 1);
        win_a(3, 3, 0, 1, 1);

        // invalid-channel samples and gaps interleaved with a span-20 window
        qa.push_back(mk(20, 0, 1, 1));
        for (int i = 0; i < 50; i++) begin
            drive_a((i % 2 == 0) ? 0 : -20, 0, 1'b1);
            drive_a(127, 1, 1'b1);
            drive_a(-128, 1, 1'b1);
            if (i % 7 == 0) drive_a(100, 0, 1'b0);
        end
        win_a(1, -1, 2, 0, 0);
        win_a(50, -50, 100, 1, 1);

        // two channels interleaved every cycle: ch0 loud, ch1 constant
        qb.push_back(mk(100, 0, 1, 1));
        qb.push_back(mk(0, 1, 1, 1));
        qc.push_back(mk(100, 0, 1, 0));
        qc.push_back(mk(0, 1, 1, 0));
        for (int k = 0; k < 100; k++)
            drive_bc((k % 2 == 0) ? (((k / 2) % 2 == 0) ? 50 : -50) : 7, k % 2);
        // both channels loud
        qb.push_back(mk(100, 0, 1, 1));
        qb.push_back(mk(100, 1, 3, 1));
        qc.push_back(mk(100, 0, 1, 0));
        qc.push_back(mk(100, 1, 3, 1));
        for (int k = 0; k < 100; k++)
            drive_bc((((k / 2) % 2) == 0) ? 50 : -50, k % 2);
        repeat (3) @(posedge clk);
        #1;

        // asynchronous reset in the middle of a partial window
        for (int i = 0; i < 30; i++) drive_a((i % 2 == 0) ? 5 : -5, 0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset span_axiod", int'(ifa.span_axiod), 0);
        check("async reset channel_triggered", int'(ifa.channel_triggered), 0);
        check("async reset triggered", int'(ifa.triggered), 0);
        check("async reset b channel_triggered", int'(ifb.channel_triggered), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap = closes_a;
        for (int i = 0; i < 49; i++) drive_a((i % 2 == 0) ? 50 : -50, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("no close after 49 samples", closes_a, snap);
        qa.push_back(mk(100, 0, 1, 1));
        drive_a(-50, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("close after 50th sample", closes_a, snap + 1);

        check("a pending expectations", qa.size(), 0);
        check("b pending expectations", qb.size(), 0);
        check("c pending expectations", qc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
